// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants and types, used by both the timing
// generator and the receiver.
package vga_timing_pkg;

    localparam int unsigned H_TOTAL     = 800;
    localparam int unsigned H_ACT_START = 144;
    localparam int unsigned H_ACT       = 640;
    localparam int unsigned V_TOTAL     = 525;
    localparam int unsigned V_ACT_START = 35;
    localparam int unsigned V_ACT       = 480;
    localparam int unsigned HSYNC_W     = 96;
    localparam int unsigned VSYNC_W     = 2;
    localparam int unsigned LOCK_FRAMES = 2;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned ERR_W = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        StSearch,
        StLineSync,
        StAcquire,
        StLocked
    } sync_state_e;

    function automatic cnt_t sat_inc(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one sync input, keeps its previous value and flags a rising edge
// of the registered copy.
module vga_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic sync_i,
    output logic sync_o,
    output logic rise_o
);

    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_i;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: recovers pixel coordinates from hsync/vsync, checks
// line and frame lengths, and emits a qualified pixel stream once locked.
module vga_timing_rx
    import vga_timing_pkg::*;
#(
    parameter int unsigned HTotal     = H_TOTAL,
    parameter int unsigned HActStart  = H_ACT_START,
    parameter int unsigned HAct       = H_ACT,
    parameter int unsigned VTotal     = V_TOTAL,
    parameter int unsigned VActStart  = V_ACT_START,
    parameter int unsigned VAct       = V_ACT,
    parameter int unsigned LockFrames = LOCK_FRAMES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic [2:0]       rgb_i,
    output logic [CNT_W-1:0] pixel_x_o,
    output logic [CNT_W-1:0] pixel_y_o,
    output logic [2:0]       pix_rgb_o,
    output logic             pix_valid_o,
    output logic             line_start_o,
    output logic             frame_start_o,
    output logic             locked_o,
    output logic             timing_err_o,
    output logic [ERR_W-1:0] err_count_o
);

    localparam cnt_t HLast     = cnt_t'(HTotal - 1);
    localparam cnt_t VLast     = cnt_t'(VTotal - 1);
    localparam cnt_t HActFirst = cnt_t'(HActStart);
    localparam cnt_t HActLast  = cnt_t'(HActStart + HAct - 1);
    localparam cnt_t VActFirst = cnt_t'(VActStart);
    localparam cnt_t VActLast  = cnt_t'(VActStart + VAct - 1);
    localparam cnt_t CntMax    = '1;

    // Stage 1
    logic        s_hs, hs_rise;
    logic        s_vs, unused_vs_rise;
    logic [2:0]  s_rgb_q;

    cnt_t        h_cnt, h_prev_q;
    cnt_t        v_cnt, v_prev_q;
    logic        vs_line_q, vs_line_d;
    logic        frame_bnd, line_bad, frame_bad, h_sat;

    sync_state_e state_q, state_d;
    logic [7:0]  good_q, good_d;
    logic        viol;

    // Stage 2
    logic             in_act;
    logic             pix_valid_q, pix_valid_d;
    cnt_t             pixel_x_q, pixel_x_d;
    cnt_t             pixel_y_q, pixel_y_d;
    logic [2:0]       pix_rgb_q, pix_rgb_d;
    logic             line_start_q, frame_start_q, locked_q, timing_err_q;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    vga_sync_edge u_hs_edge (
        .clk    (clk),
        .reset  (reset),
        .sync_i (hsync_i),
        .sync_o (s_hs),
        .rise_o (hs_rise)
    );

    vga_sync_edge u_vs_edge (
        .clk    (clk),
        .reset  (reset),
        .sync_i (vsync_i),
        .sync_o (s_vs),
        .rise_o (unused_vs_rise)
    );

    // h_cnt/v_cnt describe the sample in s_*; *_prev_q hold the previous sample's values.
    always_comb begin
        h_cnt     = hs_rise ? '0 : sat_inc(h_prev_q);
        frame_bnd = hs_rise & s_vs & ~vs_line_q;
        if (frame_bnd) begin
            v_cnt = '0;
        end else if (hs_rise) begin
            v_cnt = sat_inc(v_prev_q);
        end else begin
            v_cnt = v_prev_q;
        end
        vs_line_d = hs_rise ? s_vs : vs_line_q;
        line_bad  = hs_rise & (h_prev_q != HLast);
        frame_bad = frame_bnd & (v_prev_q != VLast);
        h_sat     = (h_cnt == CntMax);
    end

    // Frame length is only meaningful once a boundary has been seen, i.e. from ACQUIRE on.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        viol    = 1'b0;
        unique case (state_q)
            StSearch: begin
                if (hs_rise) state_d = StLineSync;
            end
            StLineSync: begin
                viol = line_bad;
                if (frame_bnd && !line_bad) begin
                    state_d = StAcquire;
                    good_d  = '0;
                end
            end
            StAcquire: begin
                viol = line_bad | frame_bad;
                if (viol) begin
                    state_d = StLineSync;
                end else if (frame_bnd) begin
                    if (32'(good_q) + 32'd1 >= LockFrames) begin
                        state_d = StLocked;
                    end else begin
                        good_d = good_q + 8'd1;
                    end
                end
            end
            StLocked: begin
                viol = line_bad | frame_bad;
                if (viol) state_d = StLineSync;
            end
            default: state_d = StSearch;
        endcase
        if (h_sat && state_q != StSearch) begin
            viol    = 1'b1;
            state_d = StSearch;
        end
    end

    always_comb begin
        in_act = (h_cnt >= HActFirst) && (h_cnt <= HActLast) &&
                 (v_cnt >= VActFirst) && (v_cnt <= VActLast);
        pix_valid_d = (state_q == StLocked) && in_act;
        pixel_x_d   = pix_valid_d ? h_cnt - HActFirst : '0;
        pixel_y_d   = pix_valid_d ? v_cnt - VActFirst : '0;
        pix_rgb_d   = pix_valid_d ? s_rgb_q : 3'b000;
        err_count_d = (viol && err_count_q != '1) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_rgb_q       <= 3'b000;
            h_prev_q      <= '0;
            v_prev_q      <= '0;
            vs_line_q     <= 1'b0;
            state_q       <= StSearch;
            good_q        <= '0;
            pix_valid_q   <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            pix_rgb_q     <= 3'b000;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            timing_err_q  <= 1'b0;
            err_count_q   <= '0;
        end else begin
            s_rgb_q       <= rgb_i;
            h_prev_q      <= h_cnt;
            v_prev_q      <= v_cnt;
            vs_line_q     <= vs_line_d;
            state_q       <= state_d;
            good_q        <= good_d;
            pix_valid_q   <= pix_valid_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            pix_rgb_q     <= pix_rgb_d;
            line_start_q  <= hs_rise;
            frame_start_q <= frame_bnd;
            locked_q      <= (state_q == StLocked);
            timing_err_q  <= viol;
            err_count_q   <= err_count_d;
        end
    end

    assign pixel_x_o     = pixel_x_q;
    assign pixel_y_o     = pixel_y_q;
    assign pix_rgb_o     = pix_rgb_q;
    assign pix_valid_o   = pix_valid_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
    assign locked_o      = locked_q;
    assign timing_err_o  = timing_err_q;
    assign err_count_o   = err_count_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx using a scaled-down raster so that whole
// frames fit in a short run.
module tb_vga_timing_rx;

    localparam int HT  = 32;
    localparam int HAS = 10;
    localparam int HA  = 16;
    localparam int VT  = 16;
    localparam int VAS = 3;
    localparam int VA  = 10;
    localparam int HSW = 4;
    localparam int VSW = 2;
    localparam int FRAME_PIX = HA * VA;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hsync_i = 1'b0;
    logic       vsync_i = 1'b0;
    logic [2:0] rgb_i = 3'b000;
    logic [9:0] pixel_x_o, pixel_y_o;
    logic [2:0] pix_rgb_o;
    logic       pix_valid_o, line_start_o, frame_start_o, locked_o, timing_err_o;
    logic [7:0] err_count_o;

    int n_checks = 0;
    int n_errs   = 0;

    int valid_cnt = 0;
    int ls_cnt    = 0;
    int fs_cnt    = 0;
    int terr_cnt  = 0;
    int rgb_bad   = 0;

    int v0, l0, f0, t0;

    vga_timing_rx #(
        .HTotal     (HT),
        .HActStart  (HAS),
        .HAct       (HA),
        .VTotal     (VT),
        .VActStart  (VAS),
        .VAct       (VA),
        .LockFrames (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .hsync_i       (hsync_i),
        .vsync_i       (vsync_i),
        .rgb_i         (rgb_i),
        .pixel_x_o     (pixel_x_o),
        .pixel_y_o     (pixel_y_o),
        .pix_rgb_o     (pix_rgb_o),
        .pix_valid_o   (pix_valid_o),
        .line_start_o  (line_start_o),
        .frame_start_o (frame_start_o),
        .locked_o      (locked_o),
        .timing_err_o  (timing_err_o),
        .err_count_o   (err_count_o)
    );

    always #5 clk = ~clk;

    // Input colour is column[2:0], so a valid pixel's colour follows from its x.
    always @(negedge clk) begin
        logic [9:0] col;
        col = pixel_x_o + 10'(HAS);
        if (pix_valid_o) begin
            valid_cnt++;
            if (pix_rgb_o !== col[2:0]) rgb_bad++;
        end
        if (line_start_o) ls_cnt++;
        if (frame_start_o) fs_cnt++;
        if (timing_err_o) terr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic hs, input logic vs, input logic [2:0] c);
        hsync_i = hs;
        vsync_i = vs;
        rgb_i   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cols(input int ln, input int from, input int to);
        for (int c = from; c <= to; c++) send(c < HSW, ln < VSW, 3'(c));
    endtask

    task automatic send_line(input int ln, input int len);
        send_cols(ln, 0, len - 1);
    endtask

    task automatic send_frame(input int nlines, input int short_ln);
        for (int l = 0; l < nlines; l++) send_line(l, (l == short_ln) ? HT - 1 : HT);
    endtask

    task automatic snap();
        v0 = valid_cnt;
        l0 = ls_cnt;
        f0 = fs_cnt;
        t0 = terr_cnt;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, pix_valid_o, 0);
        check({tag, "_locked"}, locked_o, 0);
        check({tag, "_errcnt"}, err_count_o, 0);
        check({tag, "_terr"}, timing_err_o, 0);
        check({tag, "_x"}, pixel_x_o, 0);
        check({tag, "_y"}, pixel_y_o, 0);
        check({tag, "_rgb"}, pix_rgb_o, 0);
        check({tag, "_ls_fs"}, {line_start_o, frame_start_o}, 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Start mid-frame so the first boundary is seen in LINE_SYNC.
        for (int l = 2; l < VT; l++) send_line(l, HT);
        send_frame(VT, -1);
        send_frame(VT, -1);
        check("no_lock_after_2_bnd", locked_o, 0);
        check("no_err_acquire", err_count_o, 0);

        // Third boundary locks; step through the first active pixel.
        snap();
        for (int l = 0; l < VAS; l++) send_line(l, HT);
        send_cols(VAS, 0, 1);
        check("line_start_col0", line_start_o, 1);
        check("locked_frame3", locked_o, 1);
        send_cols(VAS, 2, HAS);
        check("valid_before_first", pix_valid_o, 0);
        send_cols(VAS, HAS + 1, HAS + 1);
        check("first_valid", pix_valid_o, 1);
        check("first_x", pixel_x_o, 0);
        check("first_y", pixel_y_o, 0);
        check("first_rgb", pix_rgb_o, HAS % 8);
        send_cols(VAS, HAS + 2, HT - 1);
        for (int l = VAS + 1; l < VT; l++) send_line(l, HT);
        check("valid_per_frame", valid_cnt - v0, FRAME_PIX);
        check("line_starts", ls_cnt - l0, VT);
        check("frame_starts", fs_cnt - f0, 1);
        check("rgb_consistent", rgb_bad, 0);

        // Short line while locked.
        snap();
        send_frame(VT, 5);
        check("short_terr", terr_cnt - t0, 1);
        check("short_errcnt", err_count_o, 1);
        check("short_unlock", locked_o, 0);
        check("short_valid", valid_cnt - v0, 3 * HA);
        send_frame(VT, -1);
        send_frame(VT, -1);
        check("relock_not_yet", locked_o, 0);
        snap();
        send_frame(VT, -1);
        check("relock", locked_o, 1);
        check("relock_valid", valid_cnt - v0, FRAME_PIX);
        check("relock_errcnt", err_count_o, 1);

        // Frame one line short while locked.
        send_frame(VT - 1, -1);
        snap();
        send_frame(VT, -1);
        check("shortframe_terr", terr_cnt - t0, 1);
        check("shortframe_errcnt", err_count_o, 2);
        check("shortframe_unlock", locked_o, 0);
        check("shortframe_no_valid", valid_cnt - v0, 0);

        // Missing hsync drops to SEARCH.
        snap();
        for (int i = 0; i < 1100; i++) send(1'b0, 1'b0, 3'b000);
        check("nohs_terr", terr_cnt - t0, 1);
        check("nohs_errcnt", err_count_o, 3);
        check("nohs_locked", locked_o, 0);
        for (int l = 2; l < VT; l++) send_line(l, HT);
        check("recover_no_err", err_count_o, 3);
        send_frame(VT, -1);
        send_frame(VT, -1);
        check("recover_no_lock_yet", locked_o, 0);

        // Reset mid active line while locked.
        for (int l = 0; l < 5; l++) send_line(l, HT);
        send_cols(5, 0, 14);
        check("pre_reset_valid", pix_valid_o, 1);
        check("pre_reset_locked", locked_o, 1);
        reset = 1'b1;
        send_cols(5, 15, 15);
        reset = 1'b0;
        check_all_zero("midline_reset");
        send_cols(5, 16, HT - 1);
        for (int l = 6; l < VT; l++) send_line(l, HT);
        send_frame(VT, -1);
        send_frame(VT, -1);
        check("reacq_not_yet", locked_o, 0);
        send_frame(VT, -1);
        check("reacq_locked", locked_o, 1);
        check("reacq_errcnt", err_count_o, 0);

        // 300 violations saturate the error counter.
        snap();
        for (int i = 0; i < 300; i++) send_line(2, HT - 1);
        send_line(2, HT);
        check("sat_pulses", terr_cnt - t0, 300);
        check("sat_errcnt", err_count_o, 255);
        check("sat_locked", locked_o, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
